// File: rtl/decoder_fsm_pkg.sv
// Shared constants for the 64b/66b RX control FSM: block type codes, state encodings
// and the CGMII replacement words (LBLOCK_R / EBLOCK_R).
package decoder_fsm_pkg;

    localparam logic [3:0] TYPE_D = 4'b1000;
    localparam logic [3:0] TYPE_S = 4'b0100;
    localparam logic [3:0] TYPE_C = 4'b0010;
    localparam logic [3:0] TYPE_T = 4'b0001;
    localparam logic [3:0] TYPE_E = 4'b0000;

    typedef enum logic [4:0] {
        RX_INIT = 5'b10000,
        RX_C    = 5'b01000,
        RX_D    = 5'b00100,
        RX_T    = 5'b00010,
        RX_E    = 5'b00001
    } rx_state_e;

    localparam logic [7:0] CHAR_IDLE  = 8'h07;
    localparam logic [7:0] CHAR_ERROR = 8'hFE;
    localparam logic [7:0] CHAR_SEQ   = 8'h9C;

    // Local fault ordered set on both halves of the word.
    localparam logic [63:0] LBLOCK_R_DATA = {CHAR_SEQ, 24'h000001, CHAR_SEQ, 24'h000001};
    localparam logic [7:0]  LBLOCK_R_CTRL = 8'h88;
    localparam logic [63:0] EBLOCK_R_DATA = {8{CHAR_ERROR}};
    localparam logic [7:0]  EBLOCK_R_CTRL = 8'hFF;

    // A terminate block is only legal when the next block starts a packet or is control.
    function automatic logic is_tok(input logic [3:0] cur, input logic [3:0] nxt);
        return (cur == TYPE_T) && ((nxt == TYPE_S) || (nxt == TYPE_C));
    endfunction

endpackage

// File: rtl/decoder_fsm_rx_block_stage.sv
// One-deep lookahead register holding the block currently under evaluation.
// A flush empties the stage and takes priority over a load.
module decoder_fsm_rx_block_stage
    import decoder_fsm_pkg::*;
#(
    parameter int unsigned NB_DATA = 64,
    parameter int unsigned NB_CTRL = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic [3:0]         i_type,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [NB_CTRL-1:0] i_ctrl,
    output logic               o_full,
    output logic [3:0]         o_type,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_CTRL-1:0] o_ctrl
);

    logic               r_full;
    logic [3:0]         r_type;
    logic [NB_DATA-1:0] r_data;
    logic [NB_CTRL-1:0] r_ctrl;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_full <= 1'b0;
            r_type <= TYPE_E;
            r_data <= '0;
            r_ctrl <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_type <= i_type;
            r_data <= i_data;
            r_ctrl <= i_ctrl;
        end
    end

    assign o_full = r_full;
    assign o_type = r_type;
    assign o_data = r_data;
    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/decoder_fsm.sv
// RX 64b/66b block-sequence checker: validates block types with one block of lookahead
// and emits decoded, EBLOCK_R or LBLOCK_R words. RX_ERR_COUNTER_EN adds o_err_count.
module decoder_fsm
    import decoder_fsm_pkg::*;
#(
    parameter int unsigned NB_DATA    = 64,
    parameter int unsigned NB_CTRL    = 8,
    parameter int unsigned NB_ERR_CNT = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [3:0]         i_rx_type,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_CTRL-1:0] i_rx_ctrl,
    input  logic               i_block_lock,
    input  logic               i_hi_ber,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic [NB_CTRL-1:0] o_rx_ctrl,
    output logic               o_valid
`ifdef RX_ERR_COUNTER_EN
    ,
    output logic [NB_ERR_CNT-1:0] o_err_count
`endif
);

    rx_state_e          r_state;
    rx_state_e          w_next_state;
    logic               w_accept;
    logic               w_lost;
    logic               w_stage_full;
    logic [3:0]         w_stage_type;
    logic [NB_DATA-1:0] w_stage_data;
    logic [NB_CTRL-1:0] w_stage_ctrl;
    logic [NB_DATA-1:0] w_dec_data;
    logic [NB_CTRL-1:0] w_dec_ctrl;
    logic               w_emit;
    logic [NB_DATA-1:0] r_rx_data;
    logic [NB_CTRL-1:0] r_rx_ctrl;
    logic               r_valid;

    assign w_accept = i_enable && i_valid;
    assign w_lost   = !i_block_lock || i_hi_ber;
    assign w_emit   = w_accept && (w_lost || w_stage_full);

    decoder_fsm_rx_block_stage #(
        .NB_DATA (NB_DATA),
        .NB_CTRL (NB_CTRL)
    ) u_stage (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_accept),
        .i_flush (w_accept && w_lost),
        .i_type  (i_rx_type),
        .i_data  (i_rx_data),
        .i_ctrl  (i_rx_ctrl),
        .o_full  (w_stage_full),
        .o_type  (w_stage_type),
        .o_data  (w_stage_data),
        .o_ctrl  (w_stage_ctrl)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= RX_INIT;
        end else if (w_accept) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_lost) begin
            w_next_state = RX_INIT;
        end else if (w_stage_full) begin
            unique case (r_state)
                RX_INIT, RX_C, RX_T: begin
                    if (w_stage_type == TYPE_C)      w_next_state = RX_C;
                    else if (w_stage_type == TYPE_S) w_next_state = RX_D;
                    else                             w_next_state = RX_E;
                end
                RX_D: begin
                    if (w_stage_type == TYPE_D)                   w_next_state = RX_D;
                    else if (is_tok(w_stage_type, i_rx_type))     w_next_state = RX_T;
                    else                                          w_next_state = RX_E;
                end
                RX_E: begin
                    if (w_stage_type == TYPE_D)                   w_next_state = RX_D;
                    else if (is_tok(w_stage_type, i_rx_type))     w_next_state = RX_T;
                    else if (w_stage_type == TYPE_C)              w_next_state = RX_C;
                    else                                          w_next_state = RX_E;
                end
                default: w_next_state = RX_E;
            endcase
        end
    end

    always_comb begin
        w_dec_data = w_stage_data;
        w_dec_ctrl = w_stage_ctrl;
        if (w_lost) begin
            w_dec_data = LBLOCK_R_DATA;
            w_dec_ctrl = LBLOCK_R_CTRL;
        end else if (w_next_state == RX_E) begin
            w_dec_data = EBLOCK_R_DATA;
            w_dec_ctrl = EBLOCK_R_CTRL;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rx_data <= LBLOCK_R_DATA;
            r_rx_ctrl <= LBLOCK_R_CTRL;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_rx_data <= w_dec_data;
                r_rx_ctrl <= w_dec_ctrl;
            end
        end
    end

    assign o_rx_data = r_rx_data;
    assign o_rx_ctrl = r_rx_ctrl;
    assign o_valid   = r_valid;

`ifdef RX_ERR_COUNTER_EN
    logic [NB_ERR_CNT-1:0] r_err_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_err_count <= '0;
        end else if (w_accept && !w_lost && w_stage_full && (w_next_state == RX_E)
                     && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_decoder_fsm.sv
// Table-driven scoreboard bench for decoder_fsm plus hand-written corner-case sequences.
// Build with RX_ERR_COUNTER_EN to also exercise the saturating error counter.
module tb_decoder_fsm;

    localparam logic [3:0] T_D = 4'b1000;
    localparam logic [3:0] T_S = 4'b0100;
    localparam logic [3:0] T_C = 4'b0010;
    localparam logic [3:0] T_T = 4'b0001;
    localparam logic [3:0] T_E = 4'b0000;
    localparam logic [63:0] LB_D = 64'h9C000001_9C000001;
    localparam logic [7:0]  LB_C = 8'h88;
    localparam logic [63:0] EB_D = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [7:0]  EB_C = 8'hFF;
`ifdef RX_ERR_COUNTER_EN
    localparam int unsigned NB_ERR = 4;
`else
    localparam int unsigned NB_ERR = 16;
`endif

    typedef struct {
        logic        rst;
        logic [3:0]  typ;
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        lock;
        logic        exp_v;
        logic [63:0] exp_d;
        logic [7:0]  exp_c;
        logic [4:0]  exp_st;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        vld = 1'b0;
    logic [3:0]  typ = T_E;
    logic [63:0] din = '0;
    logic [7:0]  cin = '0;
    logic        lock = 1'b1;
    logic        hi_ber = 1'b0;
    logic [63:0] dout;
    logic [7:0]  cout;
    logic        vout;
`ifdef RX_ERR_COUNTER_EN
    logic [NB_ERR-1:0] err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    word_t sb[$];
    vec_t tbl[0:21];

    decoder_fsm #(
        .NB_DATA    (64),
        .NB_CTRL    (8),
        .NB_ERR_CNT (NB_ERR)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_valid      (vld),
        .i_rx_type    (typ),
        .i_rx_data    (din),
        .i_rx_ctrl    (cin),
        .i_block_lock (lock),
        .i_hi_ber     (hi_ber),
        .o_rx_data    (dout),
        .o_rx_ctrl    (cout),
        .o_valid      (vout)
`ifdef RX_ERR_COUNTER_EN
        ,
        .o_err_count  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drive(input logic [3:0] t, input logic [63:0] d, input logic [7:0] c);
        typ = t;
        din = d;
        cin = c;
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] t, input logic [63:0] d,
                                input logic [7:0] c, input logic l, input logic ev,
                                input logic [63:0] ed, input logic [7:0] ec,
                                input logic [4:0] st);
        vec_t v;
        v = '{rst: r, typ: t, data: d, ctrl: c, lock: l, exp_v: ev, exp_d: ed, exp_c: ec,
              exp_st: st};
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        word_t w;
        if (v.rst) do_reset();
        lock = v.lock;
        if (v.exp_v) sb.push_back('{d: v.exp_d, c: v.exp_c});
        drive(v.typ, v.data, v.ctrl);
        lock = 1'b1;
        check($sformatf("vec%0d valid", idx), {63'd0, vout}, {63'd0, v.exp_v});
        if (vout) begin
            if (sb.size() == 0) begin
                check($sformatf("vec%0d unexpected word", idx), dout, 64'hx);
            end else begin
                w = sb.pop_front();
                check($sformatf("vec%0d data", idx), dout, w.d);
                check($sformatf("vec%0d ctrl", idx), {56'd0, cout}, {56'd0, w.c});
            end
        end else if (v.exp_v && sb.size() != 0) begin
            void'(sb.pop_back());
        end
        if (v.exp_st != 5'd0) check($sformatf("vec%0d state", idx), {59'd0, dut.r_state},
                                    {59'd0, v.exp_st});
    endtask

    initial begin
        // Clean C,S,D,D,T,C packet; each word appears one beat late.
        tbl[0]  = mk(1, T_C, 64'h0707070707070707, 8'hFF, 1, 0, '0, '0, 0);
        tbl[1]  = mk(0, T_S, 64'hFB55555555555555, 8'h80, 1, 1, 64'h0707070707070707, 8'hFF, 0);
        tbl[2]  = mk(0, T_D, 64'h1111111111111111, 8'h00, 1, 1, 64'hFB55555555555555, 8'h80, 0);
        tbl[3]  = mk(0, T_D, 64'h2222222222222222, 8'h00, 1, 1, 64'h1111111111111111, 8'h00, 0);
        tbl[4]  = mk(0, T_T, 64'hFD07070707070707, 8'hFF, 1, 1, 64'h2222222222222222, 8'h00, 0);
        tbl[5]  = mk(0, T_C, 64'h07070707070707AA, 8'hFF, 1, 1, 64'hFD07070707070707, 8'hFF,
                     5'b00010);
        tbl[6]  = mk(0, T_C, 64'h0707070707070707, 8'hFF, 1, 1, 64'h07070707070707AA, 8'hFF,
                     5'b01000);
        // From RX_C: C,D,C -> D becomes EBLOCK_R, following C recovers.
        tbl[7]  = mk(0, T_C, 64'h0707070707070733, 8'hFF, 1, 1, 64'h0707070707070707, 8'hFF, 0);
        tbl[8]  = mk(0, T_D, 64'h3333333333333333, 8'h00, 1, 1, 64'h0707070707070733, 8'hFF, 0);
        tbl[9]  = mk(0, T_C, 64'h0707070707070744, 8'hFF, 1, 1, EB_D, EB_C, 5'b00001);
        tbl[10] = mk(0, T_C, 64'h0707070707070755, 8'hFF, 1, 1, 64'h0707070707070744, 8'hFF,
                     5'b01000);
        // Lock loss mid-packet, then relock.
        tbl[11] = mk(1, T_S, 64'hFB66666666666666, 8'h80, 1, 0, '0, '0, 0);
        tbl[12] = mk(0, T_D, 64'h4444444444444444, 8'h00, 1, 1, 64'hFB66666666666666, 8'h80, 0);
        tbl[13] = mk(0, T_D, 64'h5555555555555555, 8'h00, 0, 1, LB_D, LB_C, 5'b10000);
        tbl[14] = mk(0, T_D, 64'h6666666666666666, 8'h00, 0, 1, LB_D, LB_C, 5'b10000);
        tbl[15] = mk(0, T_C, 64'h0707070707070766, 8'hFF, 1, 0, '0, '0, 5'b10000);
        tbl[16] = mk(0, T_C, 64'h0707070707070777, 8'hFF, 1, 1, 64'h0707070707070766, 8'hFF,
                     5'b01000);
        // T followed by D fails the lookahead check.
        tbl[17] = mk(1, T_S, 64'hFB77777777777777, 8'h80, 1, 0, '0, '0, 0);
        tbl[18] = mk(0, T_D, 64'h8888888888888888, 8'h00, 1, 1, 64'hFB77777777777777, 8'h80, 0);
        tbl[19] = mk(0, T_T, 64'hFD07070707070707, 8'hFF, 1, 1, 64'h8888888888888888, 8'h00, 0);
        tbl[20] = mk(0, T_D, 64'h9999999999999999, 8'h00, 1, 1, EB_D, EB_C, 5'b00001);
        tbl[21] = mk(0, T_C, 64'h0707070707070788, 8'hFF, 1, 1, 64'h9999999999999999, 8'h00,
                     5'b00100);

        do_reset();
        check("reset valid", {63'd0, vout}, 64'd0);
        check("reset data", dout, LB_D);
        check("reset ctrl", {56'd0, cout}, {56'd0, LB_C});
`ifdef RX_ERR_COUNTER_EN
        check("reset err_count", {60'd0, err_cnt}, 64'd0);
`endif

        for (int i = 0; i < 22; i++) run_vec(i, tbl[i]);
`ifdef RX_ERR_COUNTER_EN
        check("err_count after T-D", {60'd0, err_cnt}, 64'd1);
`endif

        // i_valid / i_enable gating, then reset mid-stream.
        do_reset();
        drive(T_C, 64'h07070707070707A1, 8'hFF);
        check("tog first beat valid", {63'd0, vout}, 64'd0);
        @(posedge clk); #1;
        check("tog idle valid", {63'd0, vout}, 64'd0);
        check("tog idle hold", dout, LB_D);
        drive(T_C, 64'h07070707070707A2, 8'hFF);
        check("tog second beat valid", {63'd0, vout}, 64'd1);
        check("tog second beat data", dout, 64'h07070707070707A1);
        @(posedge clk); #1;
        check("tog gap valid", {63'd0, vout}, 64'd0);
        check("tog gap hold", dout, 64'h07070707070707A1);
        en = 1'b0;
        drive(T_C, 64'h07070707070707A3, 8'hFF);
        check("enable low valid", {63'd0, vout}, 64'd0);
        check("enable low hold", dout, 64'h07070707070707A1);
        en = 1'b1;
        drive(T_C, 64'h07070707070707A4, 8'hFF);
        check("enable back valid", {63'd0, vout}, 64'd1);
        check("enable back data", dout, 64'h07070707070707A2);
        rst = 1'b1;
        drive(T_C, 64'h07070707070707A5, 8'hFF);
        rst = 1'b0;
        check("midreset valid", {63'd0, vout}, 64'd0);
        check("midreset data", dout, LB_D);
        check("midreset ctrl", {56'd0, cout}, {56'd0, LB_C});
        drive(T_C, 64'h07070707070707A6, 8'hFF);
        check("after reset first beat valid", {63'd0, vout}, 64'd0);

`ifdef RX_ERR_COUNTER_EN
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(T_E, EB_D, 8'hFF);
            if (i == 3) check("err_count ramp", {60'd0, err_cnt}, 64'd3);
        end
        check("err_count saturate", {60'd0, err_cnt}, 64'hF);
        check("E stream data", dout, EB_D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_fsm.md
Name: decoder_fsm

Overview:
- Receive-side 64b/66b control state machine for the 100GbE PCS; the RX counterpart of the transmit encoder FSM.
- Sits after the block classifier/decoder, which supplies a decoded 64-bit CGMII word, an 8-bit control mask and a 4-bit block type.
- Checks the block-type sequence using a one-block lookahead, and emits either the decoded word, an error word (EBLOCK_R) or local fault (LBLOCK_R) toward the CGMII side.

Parameters:
- NB_DATA, 64, CGMII data width (8 lanes x 8 bits, lane 0 in MSBs).
- NB_CTRL, 8, control mask width, one bit per lane, lane 0 in MSB.
- NB_ERR_CNT, 16, width of optional error counter.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  global clock enable.
- i_valid  in  1  input block valid; a beat is accepted when i_enable && i_valid.
- i_rx_type  in  4  block type: D=4'b1000, S=4'b0100, C=4'b0010, T=4'b0001, E=4'b0000.
- i_rx_data  in  NB_DATA  decoded CGMII data for the block.
- i_rx_ctrl  in  NB_CTRL  decoded CGMII control mask.
- i_block_lock  in  1  block lock from the lock FSM; 0 = unlocked.
- i_hi_ber  in  1  high-BER indication from the BER monitor.
- o_rx_data  out  NB_DATA  checked CGMII data.
- o_rx_ctrl  out  NB_CTRL  checked CGMII control.
- o_valid  out  1  output word valid, one clock per emitted word.
- o_err_count  out  NB_ERR_CNT  present only with RX_ERR_COUNTER_EN.

Behaviour:
- Reset:
  - state = RX_INIT, lookahead stage empty, o_valid = 0.
  - o_rx_data = 64'h9C000001_9C000001 and o_rx_ctrl = 8'h88 (LBLOCK_R).
  - o_err_count = 0.
- Lookahead stage (one deep):
  - On each accepted beat, the stage loads {type, data, ctrl} from the inputs and sets stage_full.
  - The FSM evaluates the stage contents as the current block, with i_rx_type as the next type.
  - No evaluation happens while the stage is empty (first beat after reset or unlock).
- Latency and output timing:
  - When block N+1 is accepted with stage_full = 1, the output registers load the decision for block N and o_valid = 1 on the following cycle.
  - o_valid = 0 otherwise.
  - Outputs hold their value when no beat is accepted.
- States: one-hot RX_INIT=10000, RX_C=01000, RX_D=00100, RX_T=00010, RX_E=00001.
- Transitions (cur = stage type, nxt = i_rx_type; TOK means T and nxt is S or C):
  - RX_INIT: C -> RX_C; S -> RX_D; else -> RX_E.
  - RX_C: C -> RX_C; S -> RX_D; else -> RX_E.
  - RX_D: D -> RX_D; TOK -> RX_T; else -> RX_E.
  - RX_T: C -> RX_C; S -> RX_D; else -> RX_E.
  - RX_E: D -> RX_D; TOK -> RX_T; C -> RX_C; else -> RX_E.
- Output data:
  - Any transition into RX_C, RX_D or RX_T passes the stage data/ctrl through.
  - Entry into or staying in RX_E outputs EBLOCK_R: data = 64'hFEFE_FEFE_FEFE_FEFE, ctrl = 8'hFF.
- Loss of lock (i_block_lock = 0 or i_hi_ber = 1, sampled on an accepted beat):
  - State is forced to RX_INIT and LBLOCK_R is output; this has priority over every transition.
  - stage_full is cleared.
  - Evaluation resumes on the second accepted beat after lock returns.
- Reset mid-packet returns everything to the reset values on the next edge; no partial frame is emitted.
- i_enable = 0 freezes the state, the stage and the outputs, and forces o_valid = 0.

Optional Feature:
- RX_ERR_COUNTER_EN defined:
  - o_err_count increments on each emitted EBLOCK_R word and saturates at all-ones.
  - LBLOCK_R words are not counted.
  - Cleared only by i_reset.
- Not defined: the port and the counter are absent.

Decomposition:
- Shared include/package holds:
  - type codes TYPE_D/S/C/T/E, identical to the TX side;
  - RX state encodings;
  - LBLOCK_R and EBLOCK_R data/ctrl constants;
  - CGMII characters: idle 0x07, error 0xFE, sequence 0x9C.
- One sub-module: rx_block_stage, the one-deep lookahead register with stage_full flag and flush input.

Test Plan:
- Lock high, beats C,S,D,D,T,C (T data 64'hFD07070707070707, ctrl 8'hFF) -> all six words passed unchanged, each one beat late; final state RX_C.
- Lock high, beats S,D,T,D -> T fails the lookahead check, so EBLOCK_R (64'hFEFE..., 8'hFF) replaces T; D following RX_E passes through; counter = 1 if enabled.
- From RX_C, beats C,D,C -> D produces EBLOCK_R; next C recovers to RX_C and passes through.
- Mid-packet S,D then i_block_lock = 0 for 2 beats -> LBLOCK_R (64'h9C0000019C000001, 8'h88), state RX_INIT; after relock the first beat produces no o_valid and the second beat evaluates the first block.
- i_valid toggled 1,0,1 with i_enable = 1 -> o_valid pulses only after accepted beats; outputs hold between pulses; i_reset mid-stream -> LBLOCK_R, o_valid = 0 next cycle.
- RX_ERR_COUNTER_EN with NB_ERR_CNT = 4: 20 consecutive E blocks -> o_err_count saturates at 4'hF.
